// File: rtl/rv32i_pkg.sv
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : Shared RV32I widths, constants and fetch state encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_t;

endpackage : rv32i_pkg

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
//  Module   : fetch_buffer
//  Brief    : Synchronous FIFO with a registered head word and flush.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_head;

    logic               w_do_pop;
    logic               w_do_push;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [WIDTH-1:0]   w_head_nxt;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_head  = r_head;

    assign w_do_pop     = i_pop & ~o_empty;
    assign w_do_push    = i_push & (~o_full | w_do_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_do_pop);

    // Head tracks the entry that will sit at the read pointer after this
    // edge; a write landing on that slot is forwarded so the head stays exact.
    assign w_head_nxt = (w_do_push && (r_wr_ptr == w_rd_ptr_nxt)) ? i_data
                                                                  : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_head <= w_head_nxt;
        end
    end

endmodule : fetch_buffer

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
//  Module   : instruction_fetch_unit
//  Brief    : RV32I fetch PC, legality check, fault FSM and decode handoff.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_BYTES = 108,
    parameter int              BUF_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_pc,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam logic [XLEN-1:0] c_last_pc = XLEN'(IMEM_BYTES - 4);

    fetch_state_t         r_state;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_fault_pc;

    logic                 w_legal;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [XLEN+ILEN-1:0] w_head;

    assign w_legal = (r_fetch_pc[1:0] == 2'b00) && (r_fetch_pc <= c_last_pc);
    assign w_pop   = if_valid & if_ready;
    assign w_push  = (r_state == FS_RUN) & w_legal & (~w_full | w_pop) & ~redirect_valid;

    fetch_buffer #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({r_fetch_pc, imem_instr}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_pc     = r_fetch_pc;
    assign if_valid    = ~w_empty;
    assign if_pc       = w_head[XLEN+ILEN-1:ILEN];
    assign if_instr    = w_head[ILEN-1:0];
    // Older buffered instructions retire before the fault becomes visible.
    assign fetch_fault = (r_state == FS_FAULT) & w_empty;
    assign fault_pc    = r_fault_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FS_RUN;
            r_fetch_pc <= RESET_PC;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_state    <= FS_RUN;
            r_fetch_pc <= redirect_pc;
            r_fault_pc <= '0;
        end else begin
            case (r_state)
                FS_RUN: begin
                    if (!w_legal) begin
                        r_state    <= FS_FAULT;
                        r_fault_pc <= r_fetch_pc;
                    end else if (w_push) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
                FS_FAULT: begin
                    r_state <= FS_FAULT;
                end
                default: begin
                    r_state <= FS_RUN;
                end
            endcase
        end
    end

endmodule : instruction_fetch_unit

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
//  Module   : tb_instruction_fetch_unit
//  Brief    : Scoreboard bench for instruction_fetch_unit with a 27-word imem.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (108),
        .BUF_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    // Known words at 0x0, 0x4, 0x8, 0x44; elsewhere "addi x<i>, x0, 0".
    function automatic logic [31:0] mem_word(input int idx);
        logic [4:0] rd;
        rd = 5'(idx);
        case (idx)
            0:       return 32'h0094_0333;
            1:       return 32'h8001_00b3;
            2:       return 32'h0020_9133;
            17:      return 32'h0041_0063;
            default: return {20'h0, rd, 7'h13};
        endcase
    endfunction

    always_comb begin
        imem_instr = 32'h0;
        if (imem_pc < 32'd108) begin
            imem_instr = mem_word(int'(imem_pc[31:2]));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(int'(pc[31:2]))});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_valid"},    64'(if_valid),    64'd0);
        check({tag, "_if_instr"},    64'(if_instr),    64'd0);
        check({tag, "_if_pc"},       64'(if_pc),       64'd0);
        check({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
        check({tag, "_fault_pc"},    64'(fault_pc),    64'd0);
        check({tag, "_imem_pc"},     64'(imem_pc),     64'd0);
    endtask

    // Monitor: every accepted handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", {if_pc, if_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("accept_pc_instr", {if_pc, if_instr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) cyc();
        check_reset_outputs("reset");

        // T1: free-running delivery of 0,4,8 starting the cycle after release
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        reset    = 1'b0;
        if_ready = 1'b1;
        cyc();
        check("t1_first_valid", 64'(if_valid), 64'd1);
        check("t1_first_pc",    64'(if_pc),    64'h0);
        check("t1_first_instr", 64'(if_instr), 64'h0094_0333);
        repeat (3) cyc();
        reset    = 1'b1;
        if_ready = 1'b0;
        repeat (2) cyc();

        // T2: backpressure fills the buffer, then release in order
        reset = 1'b0;
        repeat (5) cyc();
        check("t2_imem_pc_hold", 64'(imem_pc),  64'h8);
        check("t2_if_pc_hold",   64'(if_pc),    64'h0);
        check("t2_if_valid",     64'(if_valid), 64'd1);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        if_ready = 1'b1;
        repeat (3) cyc();
        if_ready = 1'b0;
        repeat (2) cyc();
        check("t3_pre_valid", 64'(if_valid), 64'd1);
        check("t3_pre_pc",    64'(if_pc),    64'hC);

        // T3: redirect discards the two buffered entries
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        cyc();
        redirect_valid = 1'b0;
        check("t3_flush_valid", 64'(if_valid), 64'd0);
        cyc();
        check("t3_target_valid", 64'(if_valid), 64'd1);
        check("t3_target_pc",    64'(if_pc),    64'h44);
        check("t3_target_instr", 64'(if_instr), 64'h0041_0063);

        // T4: run sequentially off the end of the 108-byte memory
        for (int a = 'h44; a <= 'h68; a += 4) expect_pc(32'(a));
        if_ready = 1'b1;
        begin
            int waited;
            waited = 0;
            while (!fetch_fault && waited < 40) begin
                cyc();
                waited++;
            end
            check("t4_fault_seen", 64'(fetch_fault), 64'd1);
        end
        check("t4_fault_pc",     64'(fault_pc), 64'h6C);
        check("t4_valid_low",    64'(if_valid), 64'd0);
        check("t4_all_consumed", 64'(exp_q.size()), 64'd0);
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        check("t4_clear_fault",    64'(fetch_fault), 64'd0);
        check("t4_clear_fault_pc", 64'(fault_pc),    64'd0);

        // T5: misaligned redirect target faults one cycle later
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2;
        cyc();
        redirect_valid = 1'b0;
        check("t5_no_fault_yet", 64'(fetch_fault), 64'd0);
        check("t5_valid0",       64'(if_valid),    64'd0);
        cyc();
        check("t5_fault",    64'(fetch_fault), 64'd1);
        check("t5_fault_pc", 64'(fault_pc),    64'h2);
        check("t5_valid1",   64'(if_valid),    64'd0);
        cyc();
        check("t5_fault_hold", 64'(fetch_fault), 64'd1);
        check("t5_valid2",     64'(if_valid),    64'd0);

        // T6: reset wins over a simultaneous redirect while full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        repeat (3) cyc();
        check("t6_full_valid",   64'(if_valid), 64'd1);
        check("t6_full_imem_pc", 64'(imem_pc),  64'h8);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        cyc();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check_reset_outputs("t6");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch_unit

`default_nettype wire
